snes_pad_emulator: RTL

//  Controller-side end of the SNES pad serial link: emulates a standard 12-button SNES pad.

---
 rtl/snes_pad_emulator.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/snes_pad_emulator.sv
// Controller side of the SNES pad link: captures 12 buttons on the host latch and
// shifts them out one bit per host clock rise, with synchronized inputs and a frame timeout.
module snes_pad_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 40000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_latch,
  input  logic        snes_clk,
  input  logic [11:0] button_data,
  output logic        serial_data,
  output logic        frame_done,
  output logic        timeout,
  output logic [15:0] poll_count
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic                   latch_prev_q, sclk_prev_q;
  logic [15:0]            shift_reg_q, shift_reg_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
  logic                   serial_data_q, serial_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            poll_count_q, poll_count_d;

  logic        latch_s, sclk_s;
  logic        latch_rise, latch_fall, sclk_rise, sclk_fall, any_edge;
  logic [15:0] frame_word;

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign any_edge   = latch_rise | latch_fall | sclk_rise | sclk_fall;
  assign frame_word = {4'b1111, (ACTIVE_LOW ? ~button_data : button_data)};

  assign serial_data = serial_data_q;
  assign frame_done  = frame_done_q;
  assign timeout     = timeout_q;
  assign poll_count  = poll_count_q;

  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], data_latch};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], snes_clk};
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    bit_cnt_d    = bit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    poll_count_d = poll_count_q;

    case (state_q)
      IDLE: begin
        if (latch_rise) begin
          state_d     = LATCH;
          shift_reg_d = frame_word;
        end
      end
      LATCH: begin
        shift_reg_d = frame_word;
        if (latch_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = 5'd0;
        end
      end
      SHIFT: begin
        // A latch rise restarts the frame and outranks a coincident clock rise.
        if (latch_rise) begin
          state_d     = LATCH;
          shift_reg_d = frame_word;
          bit_cnt_d   = 5'd0;
        end else if (sclk_rise) begin
          shift_reg_d = {1'b0, shift_reg_q[15:1]};
          bit_cnt_d   = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
            poll_count_d = poll_count_q + 16'd1;
          end
        end
      end
      DONE: begin
        if (latch_rise) begin
          state_d     = LATCH;
          shift_reg_d = frame_word;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == LATCH || state_q == SHIFT) begin
      if (any_edge) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == IDLE_MAX) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end

    case (state_q)
      IDLE:        serial_data_d = 1'b1;
      LATCH,SHIFT: serial_data_d = shift_reg_q[0];
      DONE:        serial_data_d = 1'b0;
      default:     serial_data_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      latch_sync_q  <= '0;
      sclk_sync_q   <= '1;
      latch_prev_q  <= 1'b0;
      sclk_prev_q   <= 1'b1;
      shift_reg_q   <= 16'hFFFF;
      bit_cnt_q     <= 5'd0;
      idle_cnt_q    <= '0;
      serial_data_q <= 1'b1;
      frame_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
      poll_count_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      latch_sync_q  <= latch_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      latch_prev_q  <= latch_s;
      sclk_prev_q   <= sclk_s;
      shift_reg_q   <= shift_reg_d;
      bit_cnt_q     <= bit_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      serial_data_q <= serial_data_d;
      frame_done_q  <= frame_done_d;
      timeout_q     <= timeout_d;
      poll_count_q  <= poll_count_d;
    end
  end

endmodule
